// File: rtl/gfx_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gfx_pattern_pkg
// Description : Shared types and constants for the gfx pattern generator.
//               Holds the pattern select encoding, the colour-bar count and
//               the generator state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package gfx_pattern_pkg;

    // Test-pattern selection.
    typedef enum logic [1:0] {
        COLOR_BARS = 2'd0,
        CHECKER    = 2'd1,
        GRADIENT   = 2'd2,
        BORDER     = 2'd3
    } pattern_e;

    // Number of vertical colour bars across the visible line.
    localparam int unsigned c_num_bars = 8;

    // Width of the bar index that walks across those bars.
    localparam int unsigned c_bar_bits = $clog2(c_num_bars);

    // Generator sequencing states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_e;

endpackage : gfx_pattern_pkg
`default_nettype wire

// File: rtl/gfx_pattern_if.sv
`default_nettype none
// ============================================================================
// Module      : gfx_pattern_if
// Description : Valid/ready pixel-write bus from the pattern generator to a
//               downstream gfx/VGA stage. Coordinates and pixel are held
//               stable by the master while valid is high and ready is low.
// Revision    : 1.0 - initial release
// ============================================================================
interface gfx_pattern_if #(
    parameter int H_WIDTH     = 12,
    parameter int V_WIDTH     = 12,
    parameter int COLOR_WIDTH = 4
);

    logic                       valid;
    logic                       ready;
    logic [H_WIDTH-1:0]         x;
    logic [V_WIDTH-1:0]         y;
    logic [3*COLOR_WIDTH-1:0]   pixel;

    modport master (
        output valid,
        output x,
        output y,
        output pixel,
        input  ready
    );

    modport slave (
        input  valid,
        input  x,
        input  y,
        input  pixel,
        output ready
    );

endinterface : gfx_pattern_if
`default_nettype wire

// File: rtl/gfx_pattern_color.sv
`default_nettype none
// ============================================================================
// Module      : gfx_pattern_color
// Description : Purely combinational mapping from pixel coordinate, bar
//               index and latched pattern to a packed {red,grn,blu} pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module gfx_pattern_color
    import gfx_pattern_pkg::*;
#(
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int COLOR_WIDTH = 4,
    parameter int H_WIDTH     = 12,
    parameter int V_WIDTH     = 12
) (
    input  pattern_e                   pattern,
    input  logic [H_WIDTH-1:0]         x,
    input  logic [V_WIDTH-1:0]         y,
    input  logic [c_bar_bits-1:0]      bar_idx,
    output logic [3*COLOR_WIDTH-1:0]   pixel
);

    localparam logic [H_WIDTH-1:0] c_x_last = H_WIDTH'(H_VISIBLE - 1);
    localparam logic [V_WIDTH-1:0] c_y_last = V_WIDTH'(V_VISIBLE - 1);

    // Select the colour for the current coordinate under the active pattern.
    always_comb begin
        pixel = '0;
        case (pattern)
            COLOR_BARS: pixel = {{COLOR_WIDTH{bar_idx[2]}},
                                 {COLOR_WIDTH{bar_idx[1]}},
                                 {COLOR_WIDTH{bar_idx[0]}}};
            CHECKER:    pixel = (x[3] ^ y[3]) ? '1 : '0;
            GRADIENT:   pixel = {x[COLOR_WIDTH-1:0], y[COLOR_WIDTH-1:0],
                                 {COLOR_WIDTH{1'b0}}};
            BORDER:     pixel = ((x == '0) || (x == c_x_last) ||
                                 (y == '0) || (y == c_y_last)) ? '1 : '0;
            default:    pixel = '0;
        endcase
    end

endmodule : gfx_pattern_color
`default_nettype wire

// File: rtl/gfx_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : gfx_pattern_gen
// Description : Test-pattern frame generator. Walks x/y over the visible
//               area, emitting one pixel per valid/ready transfer. Frames are
//               started by 'start' and repeat while 'continuous' is high.
//               Optional completed-frame counter enabled by defining
//               GFX_PATTERN_GEN_FRAME_CNT_EN; otherwise frame_cnt reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module gfx_pattern_gen
    import gfx_pattern_pkg::*;
#(
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int COLOR_WIDTH = 4,
    parameter int H_WIDTH     = 12,
    parameter int V_WIDTH     = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 continuous,
    input  pattern_e             pattern,
    gfx_pattern_if.master        m_gfx,
    output logic                 busy,
    output logic                 frame_done,
    output logic [15:0]          frame_cnt
);

    localparam logic [H_WIDTH-1:0]    c_x_last   = H_WIDTH'(H_VISIBLE - 1);
    localparam logic [V_WIDTH-1:0]    c_y_last   = V_WIDTH'(V_VISIBLE - 1);
    // Bar width is a compile-time constant, so no divider is built.
    localparam logic [H_WIDTH-1:0]    c_bar_last = H_WIDTH'(H_VISIBLE / c_num_bars - 1);
    localparam logic [c_bar_bits-1:0] c_bar_one  = c_bar_bits'(1);

    gen_state_e                  r_state;
    gen_state_e                  w_state_nxt;
    logic [H_WIDTH-1:0]          r_x;
    logic [V_WIDTH-1:0]          r_y;
    logic [H_WIDTH-1:0]          r_bar_cnt;
    logic [c_bar_bits-1:0]       r_bar_idx;
    pattern_e                    r_pat;
    logic [3*COLOR_WIDTH-1:0]    w_color;
    logic                        w_run;
    logic                        w_xfer;
    logic                        w_last_xfer;

    assign w_run       = (r_state == ST_RUN);
    assign w_xfer      = w_run && m_gfx.ready;
    assign w_last_xfer = w_xfer && (r_x == c_x_last) && (r_y == c_y_last);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: start leaves IDLE; the last-pixel handshake ends the run
    // unless continuous is high at that moment.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last_xfer && !continuous) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Coordinate, bar tracking and pattern latch; all advance only on a
    // transfer so outputs stay frozen under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_y       <= '0;
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
            r_pat     <= COLOR_BARS;
        end else if (!w_run) begin
            if (start) begin
                r_x       <= '0;
                r_y       <= '0;
                r_bar_cnt <= '0;
                r_bar_idx <= '0;
                r_pat     <= pattern;
            end
        end else if (w_xfer) begin
            if (r_x == c_x_last) begin
                r_x       <= '0;
                r_bar_cnt <= '0;
                r_bar_idx <= '0;
                if (r_y == c_y_last) begin
                    r_y   <= '0;
                    r_pat <= pattern;
                end else begin
                    r_y   <= r_y + V_WIDTH'(1);
                end
            end else begin
                r_x <= r_x + H_WIDTH'(1);
                if (r_bar_cnt == c_bar_last) begin
                    r_bar_cnt <= '0;
                    r_bar_idx <= r_bar_idx + c_bar_one;
                end else begin
                    r_bar_cnt <= r_bar_cnt + H_WIDTH'(1);
                end
            end
        end
    end

    gfx_pattern_color #(
        .H_VISIBLE   (H_VISIBLE),
        .V_VISIBLE   (V_VISIBLE),
        .COLOR_WIDTH (COLOR_WIDTH),
        .H_WIDTH     (H_WIDTH),
        .V_WIDTH     (V_WIDTH)
    ) u_color (
        .pattern (r_pat),
        .x       (r_x),
        .y       (r_y),
        .bar_idx (r_bar_idx),
        .pixel   (w_color)
    );

    // Pixel is forced to zero outside RUN so reset and idle present black.
    assign m_gfx.valid = w_run;
    assign m_gfx.x     = r_x;
    assign m_gfx.y     = r_y;
    assign m_gfx.pixel = w_run ? w_color : '0;
    assign busy        = w_run;
    assign frame_done  = w_last_xfer;

`ifdef GFX_PATTERN_GEN_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_frame_cnt <= '0;
        else if (w_last_xfer) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

endmodule : gfx_pattern_gen
`default_nettype wire

// File: tb/tb_gfx_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_gfx_pattern_gen
// Description : Self-checking bench for gfx_pattern_gen at H=16, V=4.
//               Scenario table plus scoreboard of expected transfers, spot
//               pixel table and a hand-written mid-frame reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gfx_pattern_gen;
    import gfx_pattern_pkg::*;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int CW = 4;
    localparam int HW = 12;
    localparam int VW = 12;
    localparam int PW = 3 * CW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        continuous;
    pattern_e    pattern;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    gfx_pattern_if #(.H_WIDTH(HW), .V_WIDTH(VW), .COLOR_WIDTH(CW)) gfx ();

    gfx_pattern_gen #(
        .H_VISIBLE(H), .V_VISIBLE(V), .COLOR_WIDTH(CW), .H_WIDTH(HW), .V_WIDTH(VW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .pattern    (pattern),
        .m_gfx      (gfx),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [HW-1:0] x;
        logic [VW-1:0] y;
        logic [PW-1:0] pix;
        logic          done;
    } exp_t;

    typedef struct {
        pattern_e pat;
        int       n;
        bit       rnd;
        int       chg_at;
        pattern_e cp;
        int       exp_done;
    } scen_t;

    typedef struct {
        int            scen;
        int            x;
        int            y;
        logic [PW-1:0] pix;
    } spot_t;

    exp_t          sb[$];
    exp_t          e;
    scen_t         scen[6];
    spot_t         spot[19];
    logic [PW-1:0] cap[V][H];
    int            checks = 0;
    int            errors = 0;
    int            xfers  = 0;
    int            dones  = 0;
    logic          p_valid, p_ready;
    logic [HW-1:0] p_x;
    logic [VW-1:0] p_y;
    logic [PW-1:0] p_pix;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Independent reference: bars by division, checker/border by rule.
    function automatic logic [PW-1:0] model_pix(input pattern_e p, input int x, input int y);
        logic [2:0] b;
        b = 3'(x / (H / 8));
        case (p)
            COLOR_BARS: return {{CW{b[2]}}, {CW{b[1]}}, {CW{b[0]}}};
            CHECKER:    return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? {PW{1'b1}} : {PW{1'b0}};
            GRADIENT:   return {CW'(x), CW'(y), {CW{1'b0}}};
            default:    return (x == 0 || x == H - 1 || y == 0 || y == V - 1) ? {PW{1'b1}} : {PW{1'b0}};
        endcase
    endfunction

    task automatic push_frame(input pattern_e p);
        exp_t t;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                t.x    = HW'(x);
                t.y    = VW'(y);
                t.pix  = model_pix(p, x, y);
                t.done = (x == H - 1) && (y == V - 1);
                sb.push_back(t);
            end
    endtask

    // Monitor: scoreboard pop on transfers, stall stability, valid==busy.
    always @(negedge clk) begin
        if (!rst_n) begin
            p_valid = 1'b0;
            p_ready = 1'b0;
        end else begin
            chk("valid_vs_busy", gfx.valid, busy);
            if (p_valid && !p_ready && gfx.valid)
                chk("stall_hold", {gfx.x, gfx.y, gfx.pixel}, {p_x, p_y, p_pix});
            if (gfx.valid && gfx.ready) begin
                xfers++;
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_x", gfx.x, e.x);
                    chk("sb_y", gfx.y, e.y);
                    chk($sformatf("sb_pix_x%0d_y%0d", e.x, e.y), gfx.pixel, e.pix);
                    chk("sb_done", frame_done, e.done);
                end
                if (gfx.x < H && gfx.y < V) cap[gfx.y][gfx.x] = gfx.pixel;
            end else begin
                chk("done_no_xfer", frame_done, 0);
            end
            if (frame_done) dones++;
            p_valid = gfx.valid;
            p_ready = gfx.ready;
            p_x     = gfx.x;
            p_y     = gfx.y;
            p_pix   = gfx.pixel;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        pattern    = COLOR_BARS;
        gfx.ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", gfx.valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xy", {gfx.x, gfx.y}, 0);
        chk("rst_pix", gfx.pixel, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_fcnt", frame_cnt, 0);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) cap[y][x] = 'x;
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("first_valid", gfx.valid, 1);
    endtask

    task automatic run_scen(input pattern_e p, input int n, input bit rnd,
                            input int chg_at, input pattern_e cp, input int exp_done);
        int x0, d0;
        bit ok;
        for (int f = 0; f < n; f++) push_frame((f == 0 || chg_at < 0) ? p : cp);
        x0 = xfers;
        d0 = dones;
        pattern    = p;
        continuous = (n > 1);
        gfx.ready  = 1'b1;
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (dones - d0 >= n) begin
                ok = 1'b1;
                break;
            end
            if (n > 1) chk("valid_cont", gfx.valid, 1);
            if (dones - d0 >= n - 1) continuous = 1'b0;
            if (chg_at >= 0 && xfers - x0 >= chg_at) pattern = cp;
            start     = (c == 5);
            gfx.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!ok) chk("timeout", 0, 1);
        chk("done_count", dones - d0, exp_done);
        chk("xfer_count", xfers - x0, H * V * n);
        chk("sb_drained", sb.size(), 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", gfx.valid, 0);
`ifdef GFX_PATTERN_GEN_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, n);
`else
        chk("frame_cnt", frame_cnt, 0);
`endif
        gfx.ready = 1'b1;
        sb.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int x0;
        scen[0] = '{COLOR_BARS, 1, 1'b0, -1, COLOR_BARS, 1};
        scen[1] = '{COLOR_BARS, 1, 1'b1, -1, COLOR_BARS, 1};
        scen[2] = '{CHECKER,    3, 1'b0, -1, CHECKER,    3};
        scen[3] = '{COLOR_BARS, 2, 1'b1, 10, GRADIENT,   2};
        scen[4] = '{BORDER,     1, 1'b0, -1, BORDER,     1};
        scen[5] = '{GRADIENT,   1, 1'b1, -1, GRADIENT,   1};

        spot[0]  = '{0, 0, 0, 12'h000};
        spot[1]  = '{0, 1, 0, 12'h000};
        spot[2]  = '{0, 2, 1, 12'h00F};
        spot[3]  = '{0, 3, 1, 12'h00F};
        spot[4]  = '{0, 4, 2, 12'h0F0};
        spot[5]  = '{0, 6, 0, 12'h0FF};
        spot[6]  = '{0, 8, 3, 12'hF00};
        spot[7]  = '{0, 15, 3, 12'hFFF};
        spot[8]  = '{2, 0, 0, 12'h000};
        spot[9]  = '{2, 8, 1, 12'hFFF};
        spot[10] = '{3, 5, 2, 12'h520};
        spot[11] = '{3, 15, 3, 12'hF30};
        spot[12] = '{4, 0, 0, 12'hFFF};
        spot[13] = '{4, 7, 0, 12'hFFF};
        spot[14] = '{4, 0, 2, 12'hFFF};
        spot[15] = '{4, 15, 1, 12'hFFF};
        spot[16] = '{4, 7, 3, 12'hFFF};
        spot[17] = '{4, 7, 1, 12'h000};
        spot[18] = '{4, 14, 2, 12'h000};

        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        pattern    = COLOR_BARS;
        gfx.ready  = 1'b1;

        for (int s = 0; s < 6; s++) begin
            do_reset();
            run_scen(scen[s].pat, scen[s].n, scen[s].rnd, scen[s].chg_at, scen[s].cp, scen[s].exp_done);
            for (int k = 0; k < 19; k++)
                if (spot[k].scen == s)
                    chk($sformatf("spot_s%0d_x%0d_y%0d", s, spot[k].x, spot[k].y),
                        cap[spot[k].y][spot[k].x], spot[k].pix);
        end

        // Mid-frame asynchronous reset, then a clean restart from (0,0).
        do_reset();
        push_frame(COLOR_BARS);
        x0 = xfers;
        pulse_start();
        for (int c = 0; c < 200 && (xfers - x0) < 20; c++) begin
            @(posedge clk); #1;
        end
        chk("reached_xfer20", (xfers - x0) >= 20, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", gfx.valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_xy", {gfx.x, gfx.y}, 0);
        chk("mid_rst_pix", gfx.pixel, 0);
        chk("mid_rst_done", frame_done, 0);
        chk("mid_rst_fcnt", frame_cnt, 0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("wait_for_start", gfx.valid, 0);
        run_scen(COLOR_BARS, 1, 1'b0, -1, COLOR_BARS, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gfx_pattern_gen
`default_nettype wire

// File: doc/gfx_pattern_gen.md
GFX_PATTERN_GEN -- requirements
Module: gfx_pattern_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line; multiple of 8, at least 16.
REQ-002 SHALL have parameter V_VISIBLE, default 480, visible lines per frame; at least 2.
REQ-003 SHALL have parameter COLOR_WIDTH, default 4, bits per color channel.
REQ-004 SHALL have parameter H_WIDTH, default 12, x-coordinate width.
REQ-005 SHALL have parameter V_WIDTH, default 12, y-coordinate width.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic in this domain.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, begin a frame when idle.
REQ-009 SHALL have port continuous, input, 1, regenerate frames back to back.
REQ-010 SHALL have port pattern, input, 2, pattern select from gfx_pattern_pkg.
REQ-011 SHALL have port m_gfx_valid, output, 1, pixel write valid.
REQ-012 SHALL have port m_gfx_ready, input, 1, downstream gfx/VGA stage accepts.
REQ-013 SHALL have port m_gfx_x, output, H_WIDTH, pixel column.
REQ-014 SHALL have port m_gfx_y, output, V_WIDTH, pixel row.
REQ-015 SHALL have port m_gfx_pixel, output, 3*COLOR_WIDTH, pixel packed {red,grn,blu}.
REQ-016 SHALL have port busy, output, 1, high in RUN.
REQ-017 SHALL have port frame_done, output, 1, one-cycle pulse on the last-pixel handshake.
REQ-018 SHALL have port frame_cnt, output, 16, completed-frame count (see Configuration).

Function
REQ-019 SHALL implement states IDLE and RUN: IDLE->RUN on start; RUN->IDLE on last-pixel handshake when continuous=0; otherwise stay in RUN.
REQ-020 SHALL assert m_gfx_valid exactly while in RUN, first valid the cycle after start is sampled.
REQ-021 SHALL hold x, y and pixel stable while valid && !ready; a transfer is valid && ready in the same cycle.
REQ-022 SHALL advance x on each transfer, wrapping x from H_VISIBLE-1 to 0 and incrementing y; y wraps from V_VISIBLE-1 to 0.
REQ-023 SHALL sample pattern only on entry to RUN and on each frame wrap; mid-frame changes are ignored.
REQ-024 SHALL ignore start while in RUN.
REQ-025 SHALL sample continuous at the last-pixel handshake; deassertion mid-frame finishes the current frame.
REQ-026 SHALL generate COLOR_BARS (0) as 8 bars, each H_VISIBLE/8 pixels wide, bar i = {COLOR_WIDTH{i[2]}, COLOR_WIDTH{i[1]}, COLOR_WIDTH{i[0]}}, using a bar counter and no divider.
REQ-027 SHALL generate CHECKER (1) as all-ones when x[3]^y[3], else zero.
REQ-028 SHALL generate GRADIENT (2) as red=x[COLOR_WIDTH-1:0], grn=y[COLOR_WIDTH-1:0], blu=0.
REQ-029 SHALL generate BORDER (3) as all-ones on x=0, x=H_VISIBLE-1, y=0 or y=V_VISIBLE-1, else zero.
REQ-030 SHALL pulse frame_done for exactly one cycle on the last-pixel handshake, with x=H_VISIBLE-1 and y=V_VISIBLE-1.

Reset
REQ-031 SHALL on rst_n low asynchronously enter IDLE and clear m_gfx_valid, x, y, pixel, busy, frame_done and frame_cnt, including mid-frame; after release, it SHALL wait for start.

Configuration
REQ-032 SHALL, with GFX_PATTERN_GEN_FRAME_CNT_EN defined, increment frame_cnt by 1 (wrapping at 16 bits) on each frame_done.
REQ-033 SHALL, without GFX_PATTERN_GEN_FRAME_CNT_EN, tie frame_cnt to 0 and instantiate no counter logic.

Structure
REQ-034 SHALL place the pattern enum (COLOR_BARS, CHECKER, GRADIENT, BORDER) and the bar-count constant 8 in package gfx_pattern_pkg.
REQ-035 SHALL put the combinational x/y/pattern->pixel mapping in sub-module gfx_pattern_color; sequencing and handshake stay in gfx_pattern_gen.

Verification
REQ-036 SHALL verify the basic frame: H=16, V=4, COLOR_BARS, ready=1, start pulse -> 64 transfers, x 0..15 per row; pixels 0x000,0x000,0x00F,0x00F,0x0F0... at x=0..3; one frame_done; then IDLE.
REQ-037 SHALL verify backpressure: ready toggled randomly -> no x/y/pixel change while valid && !ready; sequence identical to the ready=1 run.
REQ-038 SHALL verify continuous mode: continuous=1 for 3 frames -> frame_done every 64 transfers; valid never drops; with the macro on, frame_cnt=3.
REQ-039 SHALL verify pattern latching: pattern set 0->2 at transfer 10 -> frame 1 stays bars; frame 2 GRADIENT with pixel(5,2)=0x520.
REQ-040 SHALL verify mid-frame reset: rst_n low at transfer 20 -> valid=0 immediately; restart gives first pixel (0,0).
REQ-041 SHALL verify BORDER: H=16, V=4 -> 0xFFF on rows 0 and 3 and columns 0 and 15, 0x000 elsewhere.
